tot_event_buffer: RTL and testbench

//  Downstream of the TOT calculators and trigger handler. On each TOT trigger, waits a holdoff
//   so the long window has settled, then snapshots TOT_SHORT/TOT_LONG as one event word.

---
 rtl/tot_event_pkg.sv | 29 ++
 rtl/tot_event_buffer_if.sv | 31 +++
 rtl/tot_event_fifo.sv | 60 ++++++
 rtl/tot_event_buffer.sv | 155 +++++++++++++++
 tb/tb_tot_event_buffer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tot_event_pkg.sv
// Shared types and constants for the TOT event buffer.
// Event word layout: {[TS16,] TOT_LONG, TOT_SHORT}; the TS field exists only with TIMESTAMP_EN.
// Optional feature macro: TIMESTAMP_EN (adds a 16-bit trigger timestamp, EW becomes 48).
package tot_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DEAD    = 2'd3
    } state_t;

    localparam int TOT_W = 16;
    localparam int TS_W  = 16;
    localparam int DROP_W = 16;

    localparam int SHORT_OFF = 0;
    localparam int LONG_OFF  = TOT_W;

`ifdef TIMESTAMP_EN
    localparam bit TS_EN  = 1'b1;
    localparam int TS_OFF = 2 * TOT_W;
`else
    localparam bit TS_EN  = 1'b0;
`endif

    localparam int EW = 2 * TOT_W + (TS_EN ? TS_W : 0);

endpackage

// File: rtl/tot_event_buffer_if.sv
// Bundle of trigger/TOT inputs, readout handshake and status outputs.
// master = trigger handler + readout side, slave = the event buffer.
// Width of count follows the FIFO address width AW.
interface tot_event_buffer_if #(
    parameter int AW = 4
);
    import tot_event_pkg::*;

    logic              trigger;
    logic [TOT_W-1:0]  tot_short;
    logic [TOT_W-1:0]  tot_long;
    logic              rd_en;
    logic [EW-1:0]     data_out;
    logic              data_valid;
    logic              empty;
    logic              full;
    logic [AW:0]       count;
    logic [DROP_W-1:0] drop_count;
    logic              busy;

    modport master (
        output trigger, tot_short, tot_long, rd_en,
        input  data_out, data_valid, empty, full, count, drop_count, busy
    );

    modport slave (
        input  trigger, tot_short, tot_long, rd_en,
        output data_out, data_valid, empty, full, count, drop_count, busy
    );

endinterface

// File: rtl/tot_event_fifo.sv
// Synchronous event FIFO with registered read port (BRAM-style storage, no reset on the array).
// Latency: write visible to a read on the next cycle; read data + valid strobe one cycle after rd_en.
// Backpressure: writes while full are discarded, reads while empty are ignored (data_out holds).
module tot_event_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int EW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [EW-1:0] wr_data,
    input  logic          rd_en,
    output logic [EW-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_wr;
    logic          do_rd;

    // Full is judged on the state before this cycle's read, so a simultaneous pop never rescues a write.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Storage array: no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointers and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/tot_event_buffer.sv
// TOT event buffer: on a trigger edge waits HOLDOFF cycles, snapshots TOT_SHORT/TOT_LONG into a FIFO.
// Latency: trigger edge to FIFO write is HOLDOFF+1 cycles; pop data one cycle after rd_en.
// Backpressure: none upstream; a capture with the FIFO full is dropped and counted (saturating).
// Optional feature macro: TIMESTAMP_EN (free-running 16-bit counter latched at the trigger edge).
module tot_event_buffer
    import tot_event_pkg::*;
#(
    parameter int HOLDOFF  = 50,
    parameter int DEADTIME = 20,
    parameter int DEPTH    = 16,
    parameter int AW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    tot_event_buffer_if.slave bus
);

    localparam int CNT_MAX = (HOLDOFF > DEADTIME) ? HOLDOFF : DEADTIME;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLDOFF  > 0) ? HOLDOFF  - 1 : 0);
    localparam logic [CW-1:0] DEAD_LOAD = CW'((DEADTIME > 0) ? DEADTIME - 1 : 0);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              busy_q;
    logic [DROP_W-1:0] drop_q;
    logic              trig_q;
    logic              trig_edge;
    logic              wr_en;
    logic              fifo_full;
    logic [EW-1:0]     event_word;

    assign trig_edge = bus.trigger & ~trig_q;

    // Previous trigger level for rising-edge detection; reset low so a level held through reset fires once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= bus.trigger;
        end
    end

`ifdef TIMESTAMP_EN
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_lat;

    // Free-running cycle counter, wraps naturally at 16'hFFFF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    // Timestamp taken at the accepted trigger edge, not at capture time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_lat <= '0;
        end else if (state == ST_IDLE && trig_edge) begin
            ts_lat <= ts;
        end
    end

    always_comb begin
        event_word = '0;
        event_word[SHORT_OFF +: TOT_W] = bus.tot_short;
        event_word[LONG_OFF  +: TOT_W] = bus.tot_long;
        event_word[TS_OFF    +: TS_W]  = ts_lat;
    end
`else
    always_comb begin
        event_word = '0;
        event_word[SHORT_OFF +: TOT_W] = bus.tot_short;
        event_word[LONG_OFF  +: TOT_W] = bus.tot_long;
    end
`endif

    // Capture FSM: holdoff countdown, one-cycle capture with drop accounting, dead-time countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            drop_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig_edge) begin
                        busy_q <= 1'b1;
                        cnt    <= HOLD_LOAD;
                        state  <= (HOLDOFF == 0) ? ST_CAPTURE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (fifo_full && (drop_q != {DROP_W{1'b1}})) begin
                        drop_q <= drop_q + 1'b1;
                    end
                    if (DEADTIME == 0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt   <= DEAD_LOAD;
                        state <= ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    if (cnt == '0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // The FIFO itself discards the write when full, matching the drop count above.
    assign wr_en = (state == ST_CAPTURE);

    tot_event_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .EW    (EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (event_word),
        .rd_en    (bus.rd_en),
        .rd_data  (bus.data_out),
        .rd_valid (bus.data_valid),
        .empty    (bus.empty),
        .full     (fifo_full),
        .count    (bus.count)
    );

    assign bus.full       = fifo_full;
    assign bus.drop_count = drop_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_tot_event_buffer.sv
// Directed bench for tot_event_buffer: table of TOT events with hand-computed event words,
// plus hand-written sequences for holdoff latency, ignored edges, full/drop, async reset, timestamp.
`timescale 1ns/1ps
module tb_tot_event_buffer;
    import tot_event_pkg::*;

    typedef struct {
        logic [15:0] s;
        logic [15:0] l;
        logic [31:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t vec [17];

    tot_event_buffer_if #(.AW(4)) bus ();

    tot_event_buffer #(
        .HOLDOFF  (50),
        .DEADTIME (20),
        .DEPTH    (16),
        .AW       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TIMESTAMP_EN
    logic [15:0] tb_ts;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= 16'h0;
        else     tb_ts <= tb_ts + 16'h1;
    end
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Called at a negedge; the following posedge sees the rising trigger.
    task automatic fire(input logic [15:0] s, input logic [15:0] l);
        bus.tot_short = s;
        bus.tot_long  = l;
        bus.trigger   = 1'b1;
        @(negedge clk);
        bus.trigger   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) timeout_fail(name);
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vec[0]  = '{16'h0001, 16'h1000, 32'h1000_0001};
        vec[1]  = '{16'h0002, 16'h2000, 32'h2000_0002};
        vec[2]  = '{16'hFFFF, 16'h0000, 32'h0000_FFFF};
        vec[3]  = '{16'h0000, 16'hFFFF, 32'hFFFF_0000};
        vec[4]  = '{16'h1234, 16'h5678, 32'h5678_1234};
        vec[5]  = '{16'hABCD, 16'hEF01, 32'hEF01_ABCD};
        vec[6]  = '{16'h00FF, 16'hFF00, 32'hFF00_00FF};
        vec[7]  = '{16'h5555, 16'hAAAA, 32'hAAAA_5555};
        vec[8]  = '{16'h0F0F, 16'hF0F0, 32'hF0F0_0F0F};
        vec[9]  = '{16'h0009, 16'h0090, 32'h0090_0009};
        vec[10] = '{16'h000A, 16'h00A0, 32'h00A0_000A};
        vec[11] = '{16'h000B, 16'h00B0, 32'h00B0_000B};
        vec[12] = '{16'h000C, 16'h00C0, 32'h00C0_000C};
        vec[13] = '{16'h000D, 16'h00D0, 32'h00D0_000D};
        vec[14] = '{16'h000E, 16'h00E0, 32'h00E0_000E};
        vec[15] = '{16'h000F, 16'h00F0, 32'h00F0_000F};
        vec[16] = '{16'hDEAD, 16'hBEEF, 32'hBEEF_DEAD};

        rst           = 1'b0;
        bus.trigger   = 1'b0;
        bus.tot_short = 16'h0;
        bus.tot_long  = 16'h0;
        bus.rd_en     = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",  bus.busy, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full",  bus.full, 0);
        check("rst_count", bus.count, 0);
        check("rst_drop",  bus.drop_count, 0);
        check("rst_valid", bus.data_valid, 0);
        check("rst_data",  bus.data_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: holdoff latency, single event, one-cycle strobe
        fire(16'd7, 16'd19);
        check("t1_busy", bus.busy, 1);
        repeat (50) @(negedge clk);
        check("t1_count_before_write", bus.count, 0);
        @(negedge clk);
        check("t1_count_after_write", bus.count, 1);
        check("t1_not_empty", bus.empty, 0);
        wait_idle("t1_idle");
        pop();
        check("t1_valid", bus.data_valid, 1);
        check("t1_data", bus.data_out[31:0], 32'h0013_0007);
        @(negedge clk);
        check("t1_valid_one_cycle", bus.data_valid, 0);
        check("t1_empty", bus.empty, 1);

        // 2: edges inside HOLD and DEAD ignored; capture samples TOT at capture time
        fire(16'h0021, 16'h0042);
        repeat (10) @(negedge clk);
        fire(16'h0033, 16'h0044);
        repeat (50) @(negedge clk);
        fire(16'h0055, 16'h0066);
        wait_idle("t2_idle");
        check("t2_count", bus.count, 1);
        check("t2_drop", bus.drop_count, 0);
        pop();
        check("t2_data", bus.data_out[31:0], 32'h0044_0033);

        // 3: 17 triggers with no reads, then drain in order
        for (int i = 0; i < 17; i++) begin
            fire(vec[i].s, vec[i].l);
            wait_idle("t3_idle");
        end
        check("t3_count", bus.count, 16);
        check("t3_full", bus.full, 1);
        check("t3_drop", bus.drop_count, 1);
        for (int i = 0; i < 16; i++) begin
            pop();
            check($sformatf("t3_valid_%0d", i), bus.data_valid, 1);
            check($sformatf("t3_data_%0d", i), bus.data_out[31:0], vec[i].exp);
        end
        check("t3_empty", bus.empty, 1);
        check("t3_count_zero", bus.count, 0);
        pop();
        check("t3_pop_empty_valid", bus.data_valid, 0);
        check("t3_pop_empty_hold", bus.data_out[31:0], vec[15].exp);

        // 4: full FIFO with a pop on the capture cycle still drops the event
        for (int i = 0; i < 16; i++) begin
            fire(vec[i].s, vec[i].l);
            wait_idle("t4_fill_idle");
        end
        check("t4_full", bus.full, 1);
        fire(vec[16].s, vec[16].l);
        repeat (50) @(negedge clk);
        pop();
        check("t4_valid", bus.data_valid, 1);
        check("t4_data", bus.data_out[31:0], vec[0].exp);
        check("t4_count", bus.count, 15);
        check("t4_drop", bus.drop_count, 2);
        check("t4_not_full", bus.full, 0);
        wait_idle("t4_idle");
        check("t4_count_after", bus.count, 15);

        // 5: async reset mid-HOLD, then a normal event
        fire(16'h0101, 16'h0202);
        repeat (20) @(negedge clk);
        check("t5_busy_hold", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_busy",  bus.busy, 0);
        check("t5_rst_count", bus.count, 0);
        check("t5_rst_empty", bus.empty, 1);
        check("t5_rst_full",  bus.full, 0);
        check("t5_rst_drop",  bus.drop_count, 0);
        check("t5_rst_valid", bus.data_valid, 0);
        check("t5_rst_data",  bus.data_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fire(16'h0303, 16'h0404);
        wait_idle("t5_idle");
        check("t5_count", bus.count, 1);
        pop();
        check("t5_data", bus.data_out[31:0], 32'h0404_0303);

`ifdef TIMESTAMP_EN
        // 6: timestamp latched at the edge, counter wraps before capture
        begin
            int n;
            n = 0;
            while (tb_ts != 16'hFFFE && n < 70000) begin
                @(negedge clk);
                n++;
            end
            if (tb_ts != 16'hFFFE) timeout_fail("t6_ts_wait");
        end
        fire(16'h0001, 16'h0002);
        wait_idle("t6_idle");
        pop();
        check("t6_ts", bus.data_out[47:32], 16'hFFFE);
        check("t6_data", bus.data_out[31:0], 32'h0002_0001);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
